// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : pc_sequencer
//  Brief    : Fetch/decode/execute sequencer that steers an external 8-bit PC
//             through hold, increment or load. Optional single-step control
//             is enabled by defining PCSEQ_STEP_EN.
//  Revision : 1.0  initial release
// ============================================================================
module pc_sequencer #(
  parameter int ALU_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] instr,
  input  logic       zflag,
  input  logic       cflag,
`ifdef PCSEQ_STEP_EN
  input  logic       run,
  input  logic       step,
`endif
  output logic       pc_en,
  output logic       PCincr,
  output logic [7:0] pc_data,
  output logic [3:0] alu_op,
  output logic       alu_en,
  output logic       halted,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_DECODE  = 3'd2,
    S_EXEC    = 3'd3,
    S_OPERAND = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  localparam logic [3:0] C_CNT_INIT = 4'(ALU_CYCLES - 1);
  localparam logic [3:0] C_OP_JMP   = 4'hC;
  localparam logic [3:0] C_OP_JZ    = 4'hD;
  localparam logic [3:0] C_OP_JC    = 4'hE;
  localparam logic [3:0] C_OP_HALT  = 4'hF;

  state_t     r_state;
  // Only the opcode nibble of the instruction register is ever consumed.
  logic [3:0] r_ir;
  logic [3:0] r_cnt;
  logic       w_go;
  logic       w_taken;

`ifdef PCSEQ_STEP_EN
  logic r_step_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_step_d <= 1'b0;
    end else begin
      r_step_d <= step;
    end
  end

  assign w_go = run | (step & ~r_step_d);
`else
  assign w_go = 1'b1;
`endif

  assign w_taken = (r_ir == C_OP_JMP) |
                   ((r_ir == C_OP_JZ) & zflag) |
                   ((r_ir == C_OP_JC) & cflag);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_ir    <= 4'h0;
      r_cnt   <= 4'h0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_FETCH;
        S_FETCH: begin
          if (w_go) begin
            r_ir    <= instr[7:4];
            r_state <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (r_ir <= 4'hB) begin
            r_cnt   <= C_CNT_INIT;
            r_state <= S_EXEC;
          end else if (r_ir == C_OP_HALT) begin
            r_state <= S_HALT;
          end else begin
            r_state <= S_OPERAND;
          end
        end
        S_EXEC: begin
          if (r_cnt != 4'h0) begin
            r_cnt <= r_cnt - 4'h1;
          end else begin
            r_state <= S_FETCH;
          end
        end
        S_OPERAND: r_state <= S_FETCH;
        S_HALT:    r_state <= S_HALT;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  // Moore decode of the state register; only OPERAND looks at the flags.
  always_comb begin
    pc_en  = 1'b0;
    PCincr = 1'b1;
    alu_en = 1'b0;
    halted = 1'b0;
    case (r_state)
      S_FETCH:   pc_en = w_go;
      S_EXEC:    alu_en = 1'b1;
      S_OPERAND: begin
        pc_en  = 1'b1;
        PCincr = ~w_taken;
      end
      S_HALT:    halted = 1'b1;
      default:   ;
    endcase
  end

  assign pc_data = instr;
  assign alu_op  = r_ir;
  assign state   = r_state;

endmodule
`default_nettype wire
